uart_rx_framer: RTL
===================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit, even, >=4.
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = parity bit follows data.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked, legal 1 or 2.
REQ-006 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port start_rx  in  1  receive enable; gates start-bit detection only.
REQ-009 SHALL have port rxd  in  1  asynchronous serial line, idle high, LSB first.
REQ-010 SHALL have port out_ready  in  1  consumer accepts word.
REQ-011 SHALL have port out_valid  out  1  data holds an unconsumed word.
REQ-012 SHALL have port data  out  DATA_W  received word.
REQ-013 SHALL have port parity_err  out  1  parity mismatch for word in data; valid while out_valid.
REQ-014 SHALL have port frame_err  out  1  one-cycle pulse, bad stop bit.
REQ-015 SHALL have port overrun  out  1  one-cycle pulse, completed word dropped.
REQ-016 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-017 SHALL pass rxd through a 2-flop synchronizer (rxd_s); no other logic samples rxd directly.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE with one down-counter cnt.
REQ-019 IDLE: start_rx=1 and rxd_s=0 -> START, cnt=CLKS_PER_BIT/2-1.
REQ-020 START at cnt=0: rxd_s=1 -> IDLE (false start, no flag); rxd_s=0 -> DATA, cnt=CLKS_PER_BIT-1, bit index 0.
REQ-021 DATA at cnt=0: shift rxd_s into MSB of shift register (right shift); after DATA_W samples -> PARITY if PARITY_EN else STOP; cnt reloads CLKS_PER_BIT-1 on every sample.
REQ-022 PARITY at cnt=0: capture sampled bit; mismatch = XOR(data bits, parity bit) != PARITY_ODD.
REQ-023 STOP at cnt=0: each of STOP_BITS samples must be 1; any 0 -> frame_err pulse, word discarded, -> WAIT_IDLE.
REQ-024 STOP last sample good -> word completes that cycle, -> IDLE; out_valid asserts the following cycle.
REQ-025 WAIT_IDLE: return to IDLE only after rxd_s=1 for CLKS_PER_BIT consecutive cycles; any 0 restarts the count.
REQ-026 Output register: out_valid&out_ready clears out_valid next cycle.
REQ-027 Completion while out_valid=1 and out_ready=0: new word dropped, old word/parity_err held, overrun pulses one cycle.
REQ-028 Completion in same cycle as out_valid&out_ready: new word loaded, out_valid stays 1, no overrun.
REQ-029 data and parity_err SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 start_rx deasserted mid-frame: current frame completes normally; no new start accepted in IDLE.
REQ-031 frame_err and overrun never both pulse for the same frame.

Reset
REQ-032 rst=1 at any clock edge, including mid-frame: state IDLE, cnt=0, shift register 0, synchronizer flops 1.
REQ-033 rst SHALL force out_valid=0, data=0, parity_err=0, frame_err=0, overrun=0, busy=0; partial frame discarded.

Verification
REQ-034 Defaults, send 0xA5 (8N1, 16 clk/bit), out_ready=1 -> one out_valid pulse, data=0xA5, parity_err=0, frame_err=0.
REQ-035 PARITY_EN=1 even, send 0x03 with parity bit 1 -> data=0x03, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-036 Send 0x5A with stop bit 0 -> frame_err one pulse, out_valid stays 0; line held low 40 cycles then high -> busy drops 16 cycles after line high.
REQ-037 out_ready=0, send 0x11 then 0x22 -> data=0x11 held, overrun pulse at 0x22 completion; raise out_ready -> 0x11 consumed, out_valid=0.
REQ-038 rxd low for 5 cycles only -> false start, busy returns 0, no outputs; separately assert rst mid-DATA -> all outputs 0 next cycle, next clean frame 0xC3 received correctly.
REQ-039 DATA_W=9, STOP_BITS=2, send 0x1FF with second stop bit 0 -> frame_err pulse, no out_valid.

Source files
------------

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - UART receive framer: synchronizer, frame FSM, single-word output register
module uart_rx_framer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_rx,
    input  logic              rxd,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] data,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(DATA_W - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [3:0]        bit_idx, bit_idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par_bit, par_bit_n;
    logic              stop_idx, stop_idx_n;
    logic              rxd_m, rxd_s;
    logic              done, bad_stop, word_perr;

    // Parity is folded over the data bits plus the received parity bit
    assign word_perr = (PARITY_EN != 0) && ((^{shreg, par_bit}) != ODD);
    assign busy      = (state != IDLE);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        par_bit_n  = par_bit;
        stop_idx_n = stop_idx;
        done       = 1'b0;
        bad_stop   = 1'b0;
        case (state)
            IDLE: begin
                if (start_rx && !rxd_s) begin
                    state_n = START;
                    cnt_n   = HALF;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (rxd_s) begin
                    state_n = IDLE;
                end else begin
                    state_n   = DATA;
                    cnt_n     = FULL;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shreg_n = {rxd_s, shreg[DATA_W-1:1]};
                    cnt_n   = FULL;
                    if (bit_idx == LAST_BIT) begin
                        state_n    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_idx_n = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    par_bit_n  = rxd_s;
                    cnt_n      = FULL;
                    state_n    = STOP;
                    stop_idx_n = 1'b0;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (!rxd_s) begin
                    bad_stop = 1'b1;
                    state_n  = WAIT_IDLE;
                    cnt_n    = FULL;
                end else if (stop_idx == LAST_STOP) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else begin
                    stop_idx_n = 1'b1;
                    cnt_n      = FULL;
                end
            end
            WAIT_IDLE: begin
                // Needs a full bit time of continuous idle before re-arming
                if (!rxd_s) begin
                    cnt_n = FULL;
                end else if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m      <= 1'b1;
            rxd_s      <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            stop_idx   <= 1'b0;
            out_valid  <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rxd_m      <= rxd;
            rxd_s      <= rxd_m;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            par_bit    <= par_bit_n;
            stop_idx   <= stop_idx_n;
            frame_err  <= bad_stop;
            overrun    <= done && out_valid && !out_ready;
            // A word completing while the old one drains replaces it without a gap
            if (done && (!out_valid || out_ready)) begin
                out_valid  <= 1'b1;
                data       <= shreg;
                parity_err <= word_perr;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
